// File: rtl/load_store_unit.sv
// Load/store front end for a 64-bit doubleword memory: lane extraction with sign/zero
// extension for loads, read-modify-write merging for partial stores, misalignment faults.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [63:0]           ReqWriteData,
    output logic                  RespValid,
    output logic [63:0]           RespData,
    output logic                  RespFault,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [63:0]           MemWriteData,
    output logic                  MemEnableRead,
    output logic                  MemEnableWrite,
    input  logic [63:0]           MemReadData
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

    state_t state_q, state_d;

    logic [2:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q, write_q;
    logic [63:0] wdata_q;

    logic                  resp_valid_q, resp_valid_d;
    logic [63:0]           resp_data_q, resp_data_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;

    logic        accept;
    logic [2:0]  align_mask, req_off;
    logic        req_fault;
    logic [63:0] rd_shift, load_ext, bit_mask, merged;
    logic [7:0]  lane_mask, byte_en;

    assign ReqReady = (state_q == S_IDLE) && !Reset;
    assign accept   = ReqValid && (state_q == S_IDLE);

    // Offset bits that must be zero for the requested size; with ALIGN_CHECK=0 they are dropped.
    always_comb begin
        unique case (ReqSize)
            2'd0:    align_mask = 3'b111;
            2'd1:    align_mask = 3'b110;
            2'd2:    align_mask = 3'b100;
            default: align_mask = 3'b000;
        endcase
        req_off   = ReqAddress[2:0] & align_mask;
        req_fault = ALIGN_CHECK && ((ReqAddress[2:0] & ~align_mask) != 3'b000);
    end

    always_comb begin
        rd_shift = MemReadData >> {off_q, 3'b000};
        unique case (size_q)
            2'd0:    load_ext = {{56{signed_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    load_ext = {{48{signed_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    load_ext = {{32{signed_q & rd_shift[31]}}, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
        unique case (size_q)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
        byte_en = lane_mask << off_q;
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign bit_mask[8*gi +: 8] = {8{byte_en[gi]}};
    end

    assign merged = (MemReadData & ~bit_mask) | ((wdata_q << {off_q, 3'b000}) & bit_mask);

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                if (req_fault)                       state_d = S_RESP;
                else if (ReqWrite && ReqSize == 2'd3) state_d = S_WR;
                else                                  state_d = S_RD;
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = write_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered; their next values are decoded from the upcoming state.
    always_comb begin
        mem_re_d     = (state_d == S_RD);
        mem_we_d     = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP);
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        if (accept) begin
            mem_addr_d = {ReqAddress[ADDR_WIDTH-1:3], 3'b000};
            if (ReqWrite && ReqSize == 2'd3) mem_wdata_d = ReqWriteData;
        end
        if (state_q == S_CAP && write_q) mem_wdata_d = merged;
        if (state_d == S_RESP && state_q != S_RESP) begin
            resp_fault_d = (state_q == S_IDLE);
            resp_data_d  = (state_q == S_CAP && !write_q) ? load_ext : 64'd0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            if (accept) begin
                off_q    <= req_off;
                size_q   <= ReqSize;
                signed_q <= ReqSigned;
                write_q  <= ReqWrite;
                wdata_q  <= ReqWriteData;
            end
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign RespValid      = resp_valid_q;
    assign RespData       = resp_data_q;
    assign RespFault      = resp_fault_q;
    assign MemAddress     = mem_addr_q;
    assign MemWriteData   = mem_wdata_q;
    assign MemEnableRead  = mem_re_q;
    assign MemEnableWrite = mem_we_q;

endmodule
